spi_byte_engine: RTL

- Hardware SPI byte shifter that sits downstream of the expansion control-decode stage. It replaces per-bit software toggling of SCK/MOSI through ctrl codes.
- The decode stage issues single-cycle strobes to this block:
  - select-write carries the new nSS value;
  - data-write carries the byte to send.
- The engine drives SCK/MOSI/nSS in SPI mode 0, captures the muxed MISO line, and presents the received byte and status back to the decode stage for the GBUS read path.

---
 rtl/spi_byte_engine.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/spi_byte_engine.sv
// SPI mode-0 byte shifter: MSB first, 16*DIV cycles from accepted WR_STB to DONE.
// Strobes arriving while BUSY are dropped and flagged on the sticky OVR bit.
module spi_byte_engine #(
  parameter int DIVW = 4,
  parameter int DIV  = 2
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       SS_WR,
  input  logic [1:0] SS_DATA,
  input  logic       WR_STB,
  input  logic [7:0] WR_DATA,
  input  logic [2:0] MISO,
  output logic       SCK,
  output logic       MOSI,
  output logic [1:0] nSS,
  output logic [7:0] RD_DATA,
  output logic       BUSY,
  output logic       DONE,
  output logic       OVR
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH} state_t;

  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(DIV - 1);

  state_t          state_q, state_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [3:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      rd_q, rd_d;
  logic [1:0]      nss_q, nss_d;
  logic            sck_q, sck_d;
  logic            mosi_q, mosi_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ovr_q, ovr_d;
  logic            misox;

  // Line 2 answers only when no slave is selected.
  assign misox = (MISO[0] & ~nss_q[0]) | (MISO[1] & ~nss_q[1]) |
                 (MISO[2] & nss_q[0] & nss_q[1]);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    rd_d    = rd_q;
    nss_d   = nss_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;

    if (SS_WR) begin
      if (busy_q) ovr_d = 1'b1;
      else        nss_d = SS_DATA;
    end

    case (state_q)
      ST_IDLE: begin
        if (WR_STB) begin
          shreg_d = WR_DATA;
          mosi_d  = WR_DATA[7];
          bit_d   = 4'd0;
          div_d   = '0;
          busy_d  = 1'b1;
          ovr_d   = 1'b0;
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (WR_STB) ovr_d = 1'b1;
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          sck_d   = 1'b1;
          shreg_d = {shreg_q[6:0], misox};
          state_d = ST_HIGH;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (WR_STB) ovr_d = 1'b1;
        if (div_q == DIV_LAST) begin
          div_d = '0;
          sck_d = 1'b0;
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd7) begin
            // Last falling edge: MOSI keeps the final bit.
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            rd_d    = shreg_q;
          end else begin
            mosi_d  = shreg_q[7];
            state_d = ST_LOW;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= 4'd0;
      shreg_q <= 8'h00;
      rd_q    <= 8'h00;
      nss_q   <= 2'b11;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      rd_q    <= rd_d;
      nss_q   <= nss_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign SCK     = sck_q;
  assign MOSI    = mosi_q;
  assign nSS     = nss_q;
  assign RD_DATA = rd_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign OVR     = ovr_q;

endmodule
